// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-to-decode instruction queue.
package fetch_pkg;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc_plus4;
  } fq_entry_t;

  localparam logic [31:0] NOP_INST     = 32'h0;
  localparam int          FQ_DEPTH_DEF = 4;

endpackage

// File: rtl/fetch_queue_if.sv
// Control bus carrying the single clock and synchronous reset into the fetch queue.
interface ctrl_bus_if (input logic clk);

  logic reset;

  modport central (input clk, input reset);
  modport master  (input clk, output reset);

endinterface

// File: rtl/fq_mem.sv
// Entry storage for the fetch queue: synchronous write, asynchronous read.
module fq_mem
  import fetch_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  fq_entry_t                wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output fq_entry_t                rdata
);

  // Contents are never reset; the queue masks the head with its empty flag.
  fq_entry_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction queue between fetch and decode; replaces the IF/ID register and
// throws away everything it holds on a redirect.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH_DEF,
  parameter int W     = 32
) (
  ctrl_bus_if.central              ctrl_bus,
  input  logic [W-1:0]             inst_F,
  input  logic [W-1:0]             pc_plus4_F,
  input  logic                     valid_F,
  output logic                     pc_enab,
  input  logic                     flush,
  input  logic                     stall_D,
  output logic [W-1:0]             inst_D,
  output logic [W-1:0]             pc_plus4_D,
  output logic                     valid_D,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;

  logic      w_full;
  logic      w_empty;
  logic      w_push;
  logic      w_pop;
  fq_entry_t w_wdata;
  fq_entry_t w_rdata;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = valid_F & ~w_full & ~flush;
  assign w_pop   = ~w_empty & ~stall_D & ~flush;
  assign w_wdata = '{inst: inst_F, pc_plus4: pc_plus4_F};

  // Occupancy lives in the counter, so the pointers may wrap freely.
  always_ff @(posedge ctrl_bus.clk) begin
    if (ctrl_bus.reset || flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  fq_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (ctrl_bus.clk),
    .we    (w_push),
    .waddr (r_wrPtr),
    .wdata (w_wdata),
    .raddr (r_rdPtr),
    .rdata (w_rdata)
  );

  // Registered-only path to the PC enable keeps stall/flush timing off fetch.
  assign pc_enab    = ~w_full;
  assign valid_D    = ~w_empty;
  assign inst_D     = w_empty ? NOP_INST : w_rdata.inst;
  assign pc_plus4_D = w_empty ? '0 : w_rdata.pc_plus4;
  assign count      = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a scoreboard queue of expected head entries.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int DEPTH = 4;

  logic        clk;
  logic [31:0] inst_F;
  logic [31:0] pc_plus4_F;
  logic        valid_F;
  logic        pc_enab;
  logic        flush;
  logic        stall_D;
  logic [31:0] inst_D;
  logic [31:0] pc_plus4_D;
  logic        valid_D;
  logic [2:0]  count;

  int compareCount;
  int errorCount;

  logic [63:0] sbQ[$];

  ctrl_bus_if bus (.clk(clk));

  fetch_queue #(.DEPTH(DEPTH), .W(32)) dut (
    .ctrl_bus   (bus.central),
    .inst_F     (inst_F),
    .pc_plus4_F (pc_plus4_F),
    .valid_F    (valid_F),
    .pc_enab    (pc_enab),
    .flush      (flush),
    .stall_D    (stall_D),
    .inst_D     (inst_D),
    .pc_plus4_D (pc_plus4_D),
    .valid_D    (valid_D),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      errorCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle, update the scoreboard, then compare the head after the edge.
  task automatic applyStimulus(input logic vF, input logic [31:0] inst, input logic [31:0] pc,
                               input logic stall, input logic fl, input logic rst);
    logic doPop;
    logic doPush;
    logic [63:0] head;
    valid_F    = vF;
    inst_F     = inst;
    pc_plus4_F = pc;
    stall_D    = stall;
    flush      = fl;
    bus.reset  = rst;
    if (rst || fl) begin
      sbQ.delete();
    end else begin
      doPop  = (sbQ.size() != 0) && !stall;
      doPush = vF && (sbQ.size() != DEPTH);
      if (doPop) void'(sbQ.pop_front());
      if (doPush) sbQ.push_back({inst, pc});
    end
    @(posedge clk);
    @(negedge clk);
    head = (sbQ.size() != 0) ? sbQ[0] : 64'h0;
    checkOutput("sb_valid_D", {63'h0, valid_D}, {63'h0, sbQ.size() != 0});
    checkOutput("sb_inst_D", {32'h0, inst_D}, {32'h0, head[63:32]});
    checkOutput("sb_pc_plus4_D", {32'h0, pc_plus4_D}, {32'h0, head[31:0]});
    checkOutput("sb_count", {61'h0, count}, 64'(sbQ.size()));
    checkOutput("sb_pc_enab", {63'h0, pc_enab}, {63'h0, sbQ.size() != DEPTH});
  endtask

  initial begin
    compareCount = 0;
    errorCount   = 0;
    valid_F = 1'b0; inst_F = '0; pc_plus4_F = '0;
    stall_D = 1'b0; flush = 1'b0; bus.reset = 1'b1;

    $display("[TB] reset");
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_count", {61'h0, count}, 64'h0);
    checkOutput("reset_valid_D", {63'h0, valid_D}, 64'h0);
    checkOutput("reset_inst_D", {32'h0, inst_D}, 64'h0);
    checkOutput("reset_pc_enab", {63'h0, pc_enab}, 64'h1);

    $display("[TB] streaming");
    applyStimulus(1'b1, 32'h20080001, 32'h4, 1'b0, 1'b0, 1'b0);
    checkOutput("stream_inst0", {32'h0, inst_D}, 64'h20080001);
    applyStimulus(1'b1, 32'h20090002, 32'h8, 1'b0, 1'b0, 1'b0);
    checkOutput("stream_inst1", {32'h0, inst_D}, 64'h20090002);
    checkOutput("stream_pc1", {32'h0, pc_plus4_D}, 64'h8);
    applyStimulus(1'b1, 32'h200A0003, 32'hC, 1'b0, 1'b0, 1'b0);
    checkOutput("stream_inst2", {32'h0, inst_D}, 64'h200A0003);
    checkOutput("stream_count", {61'h0, count}, 64'h1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    $display("[TB] fill and back-pressure");
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b1, 32'h100 + 32'(i), 32'(4 * i), 1'b1, 1'b0, 1'b0);
      if (i == 4) checkOutput("fill_pc_enab_full", {63'h0, pc_enab}, 64'h0);
    end
    checkOutput("fill_count_full", {61'h0, count}, 64'h4);
    checkOutput("fill_head", {32'h0, inst_D}, 64'h101);
    applyStimulus(1'b1, 32'h105, 32'h14, 1'b0, 1'b0, 1'b0);
    checkOutput("bp_count_after_pop", {61'h0, count}, 64'h3);
    checkOutput("bp_pc_enab_after_pop", {63'h0, pc_enab}, 64'h1);
    checkOutput("bp_head2", {32'h0, inst_D}, 64'h102);
    applyStimulus(1'b1, 32'h105, 32'h14, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("bp_drained", {61'h0, count}, 64'h0);

    $display("[TB] flush");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h300 + 32'(i), 32'h40 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
    checkOutput("flush_pre_count", {61'h0, count}, 64'h3);
    applyStimulus(1'b1, 32'hDEADBEEF, 32'h99, 1'b0, 1'b1, 1'b0);
    checkOutput("flush_count", {61'h0, count}, 64'h0);
    checkOutput("flush_valid_D", {63'h0, valid_D}, 64'h0);
    checkOutput("flush_inst_D", {32'h0, inst_D}, 64'h0);
    applyStimulus(1'b1, 32'h8C080000, 32'h10, 1'b1, 1'b0, 1'b0);
    checkOutput("post_flush_inst", {32'h0, inst_D}, 64'h8C080000);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    $display("[TB] wrap-around");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 32'hA000 + 32'(i), 32'h200 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
      checkOutput("wrap_inst", {32'h0, inst_D}, 64'hA000 + 64'(i));
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("wrap_empty", {63'h0, valid_D}, 64'h0);

    $display("[TB] reset mid-operation");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'h500 + 32'(i), 32'(4 * i), 1'b1, 1'b0, 1'b0);
    checkOutput("mid_full", {63'h0, pc_enab}, 64'h0);
    applyStimulus(1'b1, 32'h5FF, 32'h0, 1'b1, 1'b0, 1'b1);
    checkOutput("mid_reset_count", {61'h0, count}, 64'h0);
    checkOutput("mid_reset_pc_enab", {63'h0, pc_enab}, 64'h1);
    checkOutput("mid_reset_valid", {63'h0, valid_D}, 64'h0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'h600 + 32'(i), 32'(4 * i), 1'b1, 1'b0, 1'b0);
    checkOutput("mid_full2", {61'h0, count}, 64'h4);
    applyStimulus(1'b1, 32'h6FF, 32'h0, 1'b1, 1'b1, 1'b1);
    checkOutput("rst_flush_count", {61'h0, count}, 64'h0);
    checkOutput("rst_flush_pc_enab", {63'h0, pc_enab}, 64'h1);
    checkOutput("rst_flush_valid", {63'h0, valid_D}, 64'h0);
    applyStimulus(1'b1, 32'h700, 32'h4, 1'b0, 1'b0, 1'b0);
    checkOutput("after_reset_push", {32'h0, inst_D}, 64'h700);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, errorCount);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction queue sitting directly downstream of the fetch stage and feeding decode.
- Buffers {inst, pc_plus4} pairs from fetch and decouples fetch from decode stalls.
- Drives the fetch-stage PC enable and discards all buffered instructions on a taken branch/redirect.
- Replaces the plain IF/ID register; decode sees a head entry plus a valid flag.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- W, 32, instruction and PC width.

Ports:
- ctrl_bus  interface (ctrl_bus_if.central)  -  carries ctrl_bus.clk (single clock, rising edge) and ctrl_bus.reset (synchronous, active-high).
- inst_F  input  W  instruction from fetch.
- pc_plus4_F  input  W  PC+4 from fetch.
- valid_F  input  1  fetch output is meaningful this cycle.
- pc_enab  output  1  to fetch PC register; 1 = fetch may advance.
- flush  input  1  redirect (pc_src_M or hazard flush); empties queue.
- stall_D  input  1  decode cannot accept the head this cycle.
- inst_D  output  W  head instruction; NOP (32'h0) when empty.
- pc_plus4_D  output  W  head PC+4; 0 when empty.
- valid_D  output  1  head is valid.
- count  output  $clog2(DEPTH)+1  occupancy, for debug and bench.

Behaviour:
- State: storage[DEPTH] of {inst, pc_plus4}; wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH; count 0..DEPTH.
- full = (count == DEPTH); empty = (count == 0).
- pc_enab = !full. It depends only on registered state, so there is no combinational path from stall_D or flush to pc_enab.
- push = valid_F & !full & !flush.
- pop = !empty & !stall_D & !flush.
- Head outputs are read combinationally from storage[rd_ptr].
  - valid_D = !empty.
  - When empty, inst_D = 32'h0 and pc_plus4_D = 0.
- Latency: an entry pushed in cycle N is presented on inst_D in cycle N+1. There is no same-cycle bypass.
- Push only: write storage[wr_ptr], wr_ptr+1, count+1.
- Pop only: rd_ptr+1, count-1.
- Push and pop in the same cycle: both pointers advance; count is unchanged.
- Full: push is blocked; pc_enab=0 holds the fetch PC, so the fetch output stays stable. Full with a pop in the same cycle: pop proceeds, push is still refused (pc_enab was 0). The next cycle sees count=DEPTH-1 and pc_enab=1.
- Empty with stall_D=1: nothing happens; valid_D=0.
- Flush has priority over everything:
  - Next cycle: rd_ptr=wr_ptr=0, count=0.
  - The incoming inst_F is dropped and the head is not consumed.
  - pc_enab is unaffected by flush; the fetch stage loads the branch target itself.
- Flush coincident with full: next cycle count=0, pc_enab=1.
- Reset (sync, active-high, priority over flush): next cycle pointers=0, count=0, valid_D=0, inst_D=0, pc_plus4_D=0, pc_enab=1. Reset mid-operation discards all entries, and storage contents are don't-care. Storage itself is not reset; outputs are masked by empty.
- Pointer wrap: wr_ptr/rd_ptr DEPTH-1 -> 0. Occupancy is tracked by count, not by pointer comparison.

Decomposition:
- Shared package fetch_pkg:
  - typedef struct packed {logic[31:0] inst; logic[31:0] pc_plus4;} fq_entry_t.
  - localparam NOP_INST = 32'h0.
  - localparam FQ_DEPTH_DEF = 4.
- One sub-module, fq_mem: DEPTH x fq_entry_t register array.
  - Synchronous write port (we, waddr, wdata) on ctrl_bus.clk.
  - Asynchronous read port (raddr, rdata).
- Pointer, count and flush control live in fetch_queue.

Test Plan:
- Reset: ctrl_bus.reset=1 for 2 cycles, then release -> count=0, valid_D=0, inst_D=32'h0, pc_enab=1.
- Streaming: valid_F=1, stall_D=0, inst_F=0x20080001/0x20090002/0x200A0003 with pc_plus4 0x4/0x8/0xC -> each appears on inst_D exactly one cycle later with matching pc_plus4_D; count stays at 1.
- Fill and back-pressure: stall_D=1, push 5 instructions -> count reaches 4, pc_enab=0 after the 4th push, 5th not accepted. Release stall_D -> pops in order 1..4, pc_enab=1 one cycle after the first pop, then 5th accepted.
- Flush: queue holding 3 entries, flush=1 with valid_F=1 and stall_D=0 -> next cycle count=0, valid_D=0, inst_D=0; the entry on inst_F that cycle is never seen. Post-flush push 0x8C080000 -> on inst_D one cycle later.
- Wrap-around: 10 consecutive push/pop cycles with distinct inst_F values -> every value emerges in order, no loss or duplication across the pointer wrap at entry 3 -> 0.
- Reset mid-operation: reset=1 while full and stall_D=1 -> next cycle count=0, pc_enab=1, valid_D=0. Flush asserted together with reset gives the identical result.
